// File: rtl/maze_link_pkg.sv
// Shared definitions for the 7-bit parallel maze-update link.
// Used by the transmitter (maze_update_tx) and the RADIO_READ receiver.
package maze_link_pkg;

  localparam int X_W   = 3;
  localparam int Y_W   = 2;
  localparam int V_W   = 2;
  localparam int BUS_W = X_W + Y_W + V_W;

  localparam int BUS_V_LO = 0;
  localparam int BUS_V_HI = BUS_V_LO + V_W - 1;
  localparam int BUS_Y_LO = BUS_V_HI + 1;
  localparam int BUS_Y_HI = BUS_Y_LO + Y_W - 1;
  localparam int BUS_X_LO = BUS_Y_HI + 1;
  localparam int BUS_X_HI = BUS_X_LO + X_W - 1;

  localparam int DEF_MAX_X = 4;
  localparam int DEF_MAX_Y = 3;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [V_W-1:0] value;
  } maze_word_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_SETUP  = 3'd1,
    TX_STROBE = 3'd2,
    TX_HOLD   = 3'd3,
    TX_GAP    = 3'd4
  } tx_state_t;

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [BUS_W-1:0] pack_word(
    logic [X_W-1:0] x,
    logic [Y_W-1:0] y,
    logic [V_W-1:0] value
  );
    logic [BUS_W-1:0] w;
    w = '0;
    w[BUS_X_HI:BUS_X_LO] = x;
    w[BUS_Y_HI:BUS_Y_LO] = y;
    w[BUS_V_HI:BUS_V_LO] = value;
    return w;
  endfunction

endpackage

// File: rtl/maze_tx_fifo.sv
// Small synchronous FIFO buffering link words ahead of the framer.
// Depth must be a power of two so the pointers wrap for free.
module maze_tx_fifo
  import maze_link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BUS_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/maze_update_tx.sv
// Maze-update link transmitter: buffers (x,y,value) updates and frames them.
// Optional odd-parity output enabled by defining MAZE_TX_PARITY_EN.
module maze_update_tx
  import maze_link_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 4,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 4,
  parameter int GAP_CYC    = 2,
  parameter int MAX_X      = DEF_MAX_X,
  parameter int MAX_Y      = DEF_MAX_Y
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  input  logic [Y_W-1:0]   in_y,
  input  logic [V_W-1:0]   in_value,
  output logic [BUS_W-1:0] bus_data,
  output logic             bus_strobe,
  output logic             busy,
  output logic [7:0]       err_count
`ifdef MAZE_TX_PARITY_EN
  ,
  output logic             bus_parity
`endif
);

  localparam int CNT_MAX = max4(SETUP_CYC, STROBE_CYC,
                                HOLD_CYC, GAP_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(GAP_CYC - 1);

  tx_state_t        state_q;
  tx_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             in_bad;
  logic             take;
  logic             fifo_push;
  logic             fifo_pop;
  logic [BUS_W-1:0] fifo_din;
  logic [BUS_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;

  assign in_ready  = !fifo_full;
  assign take      = in_valid && in_ready;
  assign in_bad    = (int'(in_x) > MAX_X) || (int'(in_y) > MAX_Y);
  assign fifo_push = take && !in_bad;
  assign fifo_din  = pack_word(in_x, in_y, in_value);
  assign busy      = (state_q != TX_IDLE) || (fifo_count != '0);

  maze_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BUS_W)
  ) u_fifo (
    .clk   (CLOCK_50),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame state and the shared per-state down-counter.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame sequencing: each state runs its cycle budget, then hands over.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          state_d  = TX_SETUP;
          cnt_d    = LD_SETUP;
          fifo_pop = 1'b1;
        end
      end
      TX_SETUP: begin
        if (cnt_q == '0) begin
          state_d = TX_STROBE;
          cnt_d   = LD_STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TX_STROBE: begin
        if (cnt_q == '0) begin
          state_d = TX_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TX_HOLD: begin
        if (cnt_q == '0) begin
          state_d = TX_GAP;
          cnt_d   = LD_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TX_GAP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            state_d  = TX_SETUP;
            cnt_d    = LD_SETUP;
            fifo_pop = 1'b1;
          end else begin
            state_d = TX_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus word loads only when a word leaves the FIFO; strobe follows state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bus_data   <= '0;
      bus_strobe <= 1'b0;
    end else begin
      if (fifo_pop) bus_data <= fifo_dout;
      bus_strobe <= (state_d == TX_STROBE);
    end
  end

  // Count rejected out-of-range updates, sticking at 255.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      err_count <= '0;
    end else if (take && in_bad && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

`ifdef MAZE_TX_PARITY_EN
  // Odd parity tracks bus_data, so it moves on the same pop edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bus_parity <= 1'b1;
    end else if (fifo_pop) begin
      bus_parity <= ~^fifo_dout;
    end
  end
`endif

endmodule

// File: tb/tb_maze_update_tx.sv
// Self-checking bench for maze_update_tx.
// Build with MAZE_TX_PARITY_EN defined to cover the parity output too.
module tb_maze_update_tx;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_x     = '0;
  logic [1:0] in_y     = '0;
  logic [1:0] in_value = '0;
  logic       in_ready;
  logic [6:0] bus_data;
  logic       bus_strobe;
  logic       busy;
  logic [7:0] err_count;
`ifdef MAZE_TX_PARITY_EN
  logic       bus_parity;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  maze_update_tx dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_value   (in_value),
    .bus_data   (bus_data),
    .bus_strobe (bus_strobe),
    .busy       (busy),
    .err_count  (err_count)
`ifdef MAZE_TX_PARITY_EN
    ,
    .bus_parity (bus_parity)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Bus monitor: records frames as a receiver would see them.
  int         rise_q[$];
  logic [6:0] obs_q[$];
  int         width_q[$];
  int         overlap = 0;
  int         slen    = 0;
  logic       prev_s  = 1'b0;
  logic [6:0] prev_d  = '0;

  always @(negedge CLOCK_50) begin
    if (bus_strobe && !prev_s) begin
      rise_q.push_back(cyc);
      obs_q.push_back(bus_data);
      slen = 0;
    end
    if (bus_strobe) slen++;
    if (!bus_strobe && prev_s) width_q.push_back(slen);
    if ((bus_data !== prev_d) && (bus_strobe || prev_s)) overlap++;
    prev_s = bus_strobe;
    prev_d = bus_data;
  end

  task automatic clear_mon();
    #1;
    rise_q.delete();
    obs_q.delete();
    width_q.delete();
    overlap = 0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic drive(input logic [2:0] x, input logic [1:0] y,
                       input logic [1:0] v);
    in_x     = x;
    in_y     = y;
    in_value = v;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus_data !== 7'd0) begin
      errors++;
      $display("FAIL reset_data: got %h want 00", bus_data);
    end
    checks++;
    if (bus_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe: got %b want 0", bus_strobe);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_err: got %0d want 0", err_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
`ifdef MAZE_TX_PARITY_EN
    checks++;
    if (bus_parity !== 1'b1) begin
      errors++;
      $display("FAIL reset_parity: got %b want 1", bus_parity);
    end
`endif
  endtask

  task automatic test_single();
    int         n;
    logic [6:0] exp;
    do_reset();
    exp = 7'b010_01_11;
    drive(3'd2, 2'd1, 2'd3);
    @(negedge CLOCK_50);
    n = cyc;
    in_valid = 1'b0;
    checks++;
    if (bus_data !== 7'd0) begin
      errors++;
      $display("FAIL single_early: got %h want 00", bus_data);
    end
    @(negedge CLOCK_50);
    checks++;
    if (bus_data !== exp) begin
      errors++;
      $display("FAIL single_data: got %b want %b", bus_data, exp);
    end
`ifdef MAZE_TX_PARITY_EN
    checks++;
    if (bus_parity !== ~^exp) begin
      errors++;
      $display("FAIL single_parity: got %b want %b", bus_parity, ~^exp);
    end
`endif
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      @(negedge CLOCK_50);
    end
    checks++;
    if (cyc !== n + 19) begin
      errors++;
      $display("FAIL single_busy_end: got cycle %0d want %0d", cyc, n + 19);
    end
    checks++;
    if (rise_q.size() != 1 || width_q.size() != 1) begin
      errors++;
      $display("FAIL single_frames: got %0d rises %0d falls want 1 1",
               rise_q.size(), width_q.size());
    end else begin
      checks++;
      if (rise_q[0] != n + 5) begin
        errors++;
        $display("FAIL single_rise: got %0d want %0d", rise_q[0], n + 5);
      end
      checks++;
      if (width_q[0] != 8) begin
        errors++;
        $display("FAIL single_width: got %0d want 8", width_q[0]);
      end
    end
    checks++;
    if (bus_data !== exp) begin
      errors++;
      $display("FAIL single_idle_hold: got %b want %b", bus_data, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] w[6];
    int         n0;
    foreach (w[k])
      w[k] = {3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3))};
    do_reset();
    drive(w[0][6:4], w[0][3:2], w[0][1:0]);
    @(negedge CLOCK_50);
    n0 = cyc;
    in_valid = 1'b0;
    @(negedge CLOCK_50);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLOCK_50);
      if (k == 4) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready3: got %b want 1", in_ready);
        end
      end
      drive(w[k][6:4], w[k][3:2], w[k][1:0]);
    end
    @(negedge CLOCK_50);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: got %b want 0", in_ready);
    end
    drive(w[5][6:4], w[5][3:2], w[5][1:0]);
    for (int i = 0; i < 40; i++) begin
      if (in_ready === 1'b1) break;
      @(negedge CLOCK_50);
    end
    checks++;
    if (cyc !== n0 + 19) begin
      errors++;
      $display("FAIL b2b_reready: got cycle %0d want %0d", cyc, n0 + 19);
    end
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_one_push: got %b want 0", in_ready);
    end
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(negedge CLOCK_50);
    end
    checks++;
    if (rise_q.size() != 6 || width_q.size() != 6) begin
      errors++;
      $display("FAIL b2b_frames: got %0d rises %0d falls want 6 6",
               rise_q.size(), width_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (obs_q[k] !== w[k]) begin
          errors++;
          $display("FAIL b2b_data%0d: got %b want %b", k, obs_q[k], w[k]);
        end
        checks++;
        if (rise_q[k] != n0 + 5 + 18 * k) begin
          errors++;
          $display("FAIL b2b_rise%0d: got %0d want %0d",
                   k, rise_q[k], n0 + 5 + 18 * k);
        end
        checks++;
        if (width_q[k] != 8) begin
          errors++;
          $display("FAIL b2b_width%0d: got %0d want 8", k, width_q[k]);
        end
      end
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL b2b_overlap: got %0d want 0", overlap);
    end
  endtask

  // Reference: frame k loads at max(accept+1, previous load+18); a word
  // occupies the FIFO from its accept edge until its load edge.
  task automatic test_pressure();
    int         a_q[$];
    int         s_q[$];
    logic [6:0] w_q[$];
    int         last_s;
    int         exp_err;
    int         occ;
    int         a;
    int         s;
    bit         in_frame;
    bit         mready;
    bit         mbusy;
    do_reset();
    last_s  = -1000;
    exp_err = 0;
    for (int i = 0; i < 400; i++) begin
      occ      = 0;
      in_frame = 0;
      foreach (a_q[k]) begin
        if (a_q[k] <= cyc && cyc < s_q[k]) occ++;
        if (s_q[k] <= cyc && cyc < s_q[k] + 18) in_frame = 1;
      end
      mready = (occ < 4);
      mbusy  = (occ > 0) || in_frame;
      checks++;
      if (in_ready !== mready) begin
        errors++;
        $display("FAIL press_ready@%0d: got %b want %b", cyc, in_ready, mready);
      end
      checks++;
      if (busy !== mbusy) begin
        errors++;
        $display("FAIL press_busy@%0d: got %b want %b", cyc, busy, mbusy);
      end
      in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) in_x = 3'($urandom_range(5, 7));
      else in_x = 3'($urandom_range(0, 4));
      in_y     = 2'($urandom_range(0, 3));
      in_value = 2'($urandom_range(0, 3));
      if (in_valid && mready) begin
        if (in_x <= 3'd4) begin
          a = cyc + 1;
          s = (a + 1 > last_s + 18) ? a + 1 : last_s + 18;
          a_q.push_back(a);
          s_q.push_back(s);
          w_q.push_back({in_x, in_y, in_value});
          last_s = s;
        end else if (exp_err < 255) begin
          exp_err++;
        end
      end
      @(negedge CLOCK_50);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cyc > last_s + 20) break;
      @(negedge CLOCK_50);
    end
    checks++;
    if (err_count !== 8'(exp_err)) begin
      errors++;
      $display("FAIL press_err: got %0d want %0d", err_count, exp_err);
    end
    checks++;
    if (rise_q.size() != w_q.size()) begin
      errors++;
      $display("FAIL press_count: got %0d frames want %0d",
               rise_q.size(), w_q.size());
    end else begin
      foreach (w_q[k]) begin
        checks++;
        if (obs_q[k] !== w_q[k] || rise_q[k] != s_q[k] + 4) begin
          errors++;
          $display("FAIL press_frame%0d: got %b@%0d want %b@%0d",
                   k, obs_q[k], rise_q[k], w_q[k], s_q[k] + 4);
        end
      end
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL press_overlap: got %0d want 0", overlap);
    end
  endtask

  task automatic test_range();
    do_reset();
    drive(3'd5, 2'd0, 2'($urandom_range(0, 3)));
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    checks++;
    if (err_count !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL range_drop: got err=%0d busy=%b want err=1 busy=0",
               err_count, busy);
    end
    drive(3'd0, 2'd3, 2'd2);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    repeat (25) @(negedge CLOCK_50);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL range_keep: got %0d frames want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== 7'b000_11_10) begin
        errors++;
        $display("FAIL range_word: got %b want 0001110", obs_q[0]);
      end
    end
    drive(3'd7, 2'd0, 2'd0);
    repeat (253) @(negedge CLOCK_50);
    checks++;
    if (err_count !== 8'd254) begin
      errors++;
      $display("FAIL range_254: got %0d want 254", err_count);
    end
    repeat (7) @(negedge CLOCK_50);
    in_valid = 1'b0;
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL range_sat: got %0d want 255", err_count);
    end
  endtask

  task automatic test_reset_mid_strobe();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(3'(k + 1), 2'(k), 2'd1);
      @(negedge CLOCK_50);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_strobe) break;
      @(negedge CLOCK_50);
    end
    checks++;
    if (bus_strobe !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach_strobe: got %b want 1", bus_strobe);
    end
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    checks++;
    if (bus_strobe !== 1'b0 || bus_data !== 7'd0 || busy !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got s=%b d=%h busy=%b rdy=%b want 0 00 0 1",
               bus_strobe, bus_data, busy, in_ready);
    end
    clear_mon();
    repeat (80) @(negedge CLOCK_50);
    checks++;
    if (rise_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_flush: got %0d frames busy=%b want 0 0",
               rise_q.size(), busy);
    end
  endtask

`ifdef MAZE_TX_PARITY_EN
  task automatic test_parity();
    do_reset();
    drive(3'd0, 2'd0, 2'd1);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if (bus_data !== 7'd1 || bus_parity !== 1'b0) begin
      errors++;
      $display("FAIL parity_one: got d=%b p=%b want 0000001 0",
               bus_data, bus_parity);
    end
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge CLOCK_50);
    end
    drive(3'd0, 2'd0, 2'd0);
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if (bus_data !== 7'd0 || bus_parity !== 1'b1) begin
      errors++;
      $display("FAIL parity_zero: got d=%b p=%b want 0000000 1",
               bus_data, bus_parity);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_pressure();
    test_range();
    test_reset_mid_strobe();
`ifdef MAZE_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maze_update_tx.md
Name: maze_update_tx

Overview:
- Transmit end of the 7-bit parallel maze-update link; the RADIO_READ receiver decodes each word into RADIO_X/RADIO_Y/VALUE.
- Accepts (x, y, value) updates through a valid/ready handshake and buffers them in a small FIFO.
- Drives each update onto the bus with a timed setup/strobe/hold/gap frame, so an asynchronous 25 MHz sampler always sees stable data.
- Sits on the FPGA side that sources maze updates, e.g. the navigation/treasure logic or a bench driver for the display top.

Parameters:
- FIFO_DEPTH, 4, number of buffered updates (power of 2, ≥2).
- SETUP_CYC, 4, cycles data is stable before strobe rises (≥1).
- STROBE_CYC, 8, cycles strobe is held high (≥1).
- HOLD_CYC, 4, cycles data is held after strobe falls (≥1).
- GAP_CYC, 2, idle cycles between frames (≥1).
- MAX_X, 4, largest legal x coordinate.
- MAX_Y, 3, largest legal y coordinate.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  update offered.
- in_ready  out  1  FIFO can accept an update.
- in_x  in  3  column 0..MAX_X.
- in_y  in  2  row 0..MAX_Y.
- in_value  in  2  cell state.
- bus_data  out  7  {x[2:0], y[1:0], value[1:0]}; bit 6 = x MSB, bits 1:0 = value.
- bus_strobe  out  1  high while the word is valid for capture.
- busy  out  1  FSM not IDLE or FIFO not empty.
- err_count  out  8  saturating count of rejected out-of-range updates.

Behaviour:
- Reset values: bus_data=0, bus_strobe=0, busy=0, err_count=0, FIFO empty, state IDLE, in_ready=1 on the first cycle after reset.
- in_ready = !fifo_full; this is combinational from the FIFO count.
- Handshake: the transfer occurs on an edge where in_valid&&in_ready.
  - If in_x>MAX_X or in_y>MAX_Y, the update is consumed but not stored, and err_count increments, saturating at 255.
  - Otherwise the word is pushed.
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP. A single down-counter is loaded on each state entry.
- IDLE → SETUP: taken when the FIFO is non-empty. On the same edge the head is popped into bus_data.
- SETUP → STROBE after SETUP_CYC cycles; bus_strobe is set high on that edge.
- STROBE → HOLD after STROBE_CYC cycles; bus_strobe is cleared on that edge.
- HOLD → GAP after HOLD_CYC cycles.
- GAP → SETUP (if the FIFO is non-empty, popping on that edge) or → IDLE, after GAP_CYC cycles.
- bus_data changes only on a pop edge and holds its last value through GAP and IDLE.
- Frame length = SETUP_CYC+STROBE_CYC+HOLD_CYC+GAP_CYC = 18 cycles at defaults.
- Latency: an update accepted at edge N into an empty FIFO with the FSM in IDLE gives bus_data valid after edge N+1 and bus_strobe high after edge N+1+SETUP_CYC (N+5 at defaults).
- Simultaneous push and pop are legal, and the count is unchanged. in_ready is evaluated before the pop, so when full no push occurs even in a pop cycle.
- FIFO ordering is strict; pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: the FIFO is flushed, the FSM goes to IDLE, and bus_strobe=0 and bus_data=0 after the reset edge. No partial frame is resumed.

Optional Feature:
- Macro MAZE_TX_PARITY_EN.
- When defined:
  - Adds output bus_parity (1 bit), odd parity over bus_data.
  - bus_parity is updated on the same pop edge as bus_data.
  - Reset value is 1, the odd parity of zero data.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package maze_link_pkg holds:
  - Field widths X_W=3, Y_W=2, V_W=2, BUS_W=7.
  - Bus bit-slice constants.
  - The tx FSM state encoding.
  - Default MAX_X/MAX_Y.
- The receiver is to use the same package.
- One natural sub-module: maze_tx_fifo. It is a synchronous FIFO with push/pop/full/empty/count, parameterised by depth and width.

Test Plan:
- Single update: push x=2,y=1,v=3 while idle → bus_data=7'b010_01_11 after the next edge; strobe high for exactly 8 cycles, starting 4 cycles after data; busy deasserts 14 cycles after strobe rises.
- Back-to-back: push 4 updates in consecutive cycles → in_ready low after the 4th with FIFO full; four frames 18 cycles apart in push order; no strobe overlap with a data change.
- Full-FIFO pressure: hold in_valid during transmission → each pop re-raises in_ready for exactly one push; no update is lost or duplicated.
- Range check: push x=5,y=0 and x=0,y=3 → first is dropped with err_count=1, second is transmitted; 260 bad pushes leave err_count=255.
- Reset mid-STROBE: assert reset for 1 cycle → bus_strobe=0, bus_data=0, busy=0, FIFO empty; previously queued words are never sent.
- MAZE_TX_PARITY_EN build: send value 7'b000_00_01 → bus_parity=0; send 7'b000_00_00 → bus_parity=1.
